pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequences the 5-stage pipeline around the decode stage: stalls IF/ID on load-use
//  hazards, squashes IF/ID and ID/EX on EX-resolved branch/jump redirects, and freezes
//  the pipe while a data-memory access waits for its ready handshake.
//  Sits beside the stage registers; drives their stall/flush enables and keeps saturating
//  stall/flush performance counters.
// PARAMETERS
//  REDIRECT_BUBBLES  1   extra IF/ID flush cycles after a redirect (sync imem latency), 0..15
//  MEM_TIMEOUT       64  max MEM_WAIT cycles before abort with mem_fault, >=2
//  CNT_W             32  width of performance counters
// PORTS
//  clk          in   1      clock, rising edge
//  rstn         in   1      asynchronous active-low reset
//  id_rs1       in   5      source register 1 of instruction in ID
//  id_rs2       in   5      source register 2 of instruction in ID
//  ex_rd        in   5      destination of instruction in EX
//  ex_mem_read  in   1      instruction in EX is a load
//  ex_redirect  in   1      branch taken / jump resolved in EX this cycle
//  mem_req      in   1      MEM stage holds a valid load/store
//  mem_ready    in   1      data memory completes access this cycle
//  perf_clr     in   1      synchronous clear of both counters
//  stall_if     out  1      hold PC
//  stall_id     out  1      hold IF/ID register
//  stall_ex     out  1      hold ID/EX register
//  stall_mem    out  1      hold EX/MEM register
//  flush_id     out  1      load NOP into IF/ID
//  flush_ex     out  1      load NOP (bubble) into ID/EX
//  mem_fault    out  1      one-cycle pulse: MEM_WAIT timed out
//  stall_cnt    out  CNT_W  cycles with stall_if=1, saturating
//  flush_cnt    out  CNT_W  cycles with flush_id=1, saturating
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, BUBBLE. Reset: state=RUN, counters=0, timeout/bubble counters=0.
//  - While rstn=0 every stall/flush output and mem_fault is forced 0.
//  - Outputs are combinational from state+inputs (same-cycle effect); state/counters registered.
//  - Priority per cycle: mem wait > redirect > load-use.
//  - mem_wait = mem_req & ~mem_ready. If set (any state): stall_if/id/ex/mem=1, flush_*=0;
//    next state MEM_WAIT, timeout counter increments. Redirect/load-use are held, not acted on
//    (EX is frozen so ex_redirect stays asserted).
//  - MEM_WAIT exits to RUN the cycle mem_ready=1 (that cycle stalls are 0 and normal rules apply).
//    If MEM_TIMEOUT cycles elapse without mem_ready: mem_fault=1 for that cycle, stalls released,
//    state -> RUN, timeout counter cleared.
//  - Redirect (no mem_wait): flush_id=flush_ex=1, stall_*=0. If REDIRECT_BUBBLES>0 -> BUBBLE
//    with bubble count=REDIRECT_BUBBLES, else stay RUN.
//  - BUBBLE: flush_id=1 each cycle, decrement count; count 1->0 returns to RUN next cycle.
//    New redirect in BUBBLE reloads count. Load-use ignored in BUBBLE (ID content is squashed).
//  - Load-use (RUN, no redirect, no mem_wait): ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 |
//    ex_rd==id_rs2) -> stall_if=stall_id=1, flush_ex=1 for exactly that cycle; state stays RUN.
//  - Counters: +1 per qualifying cycle, saturate at all-ones; perf_clr wins over increment.
//  - Reset asserted mid-MEM_WAIT/BUBBLE: immediate return to RUN, no mem_fault.
// STRUCTURE
//  - cpu_pkg: hazard_state_t enum {RUN, MEM_WAIT, BUBBLE}; localparam NOP_INSTR=32'h0000_0013.
//  - One sub-module: sat_counter #(W) (clk, rstn, clr, inc, q), instantiated twice.
//  - FSM, timeout counter, bubble counter and hazard compare live in this module.
// TESTING
//  1 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> 1 cycle stall_if=stall_id=flush_ex=1;
//    ex_rd=0 same case -> no stall.
//  2 Redirect, REDIRECT_BUBBLES=2: ex_redirect pulse -> flush_id=flush_ex=1, then flush_id=1
//    for 2 cycles, RUN; flush_cnt=3.
//  3 mem_req=1, mem_ready low 4 cycles -> all four stalls=1 for 4 cycles, released on the ready
//    cycle; stall_cnt=4.
//  4 Redirect and mem_wait together -> stall only; redirect flush on the mem_ready cycle.
//  5 MEM_TIMEOUT=8, mem_ready stuck 0 -> mem_fault single pulse at 8th wait cycle, state RUN.
//  6 rstn low mid-BUBBLE and with CNT_W=4 counter at 15 -> outputs 0, counters 0;
//    saturation holds 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : controller FSM state (RUN / MEM_WAIT / BUBBLE)
//   NOP_INSTR      : encoding the stage registers load on a flush (addi x0, x0, 0)
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        BUBBLE
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset (count -> 0)
//   clr  : synchronous clear, takes priority over inc
//   inc  : count this cycle
//   q    : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a 5-stage pipeline, sitting beside the stage registers.
// Stalls IF/ID on load-use, squashes IF/ID and ID/EX on EX-resolved redirects (plus
// REDIRECT_BUBBLES extra IF/ID squash cycles), and freezes the whole pipe while a data
// memory access waits for mem_ready, aborting with a mem_fault pulse after MEM_TIMEOUT.
// Ports:
//   clk, rstn                      clock / asynchronous active-low reset
//   id_rs1, id_rs2                 sources of the instruction in ID
//   ex_rd, ex_mem_read             destination / is-load of the instruction in EX
//   ex_redirect                    taken branch or jump resolved in EX
//   mem_req, mem_ready             MEM stage access pending / completing
//   perf_clr                       synchronous clear of both perf counters
//   stall_if/id/ex/mem             hold PC and stage registers
//   flush_id, flush_ex             load NOP into IF/ID, ID/EX
//   mem_fault                      one-cycle pulse on memory wait timeout
//   stall_cnt, flush_cnt           saturating cycle counts of stall_if / flush_id
module pipeline_hazard_controller
    import cpu_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 64,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned BUB_W = 4;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);

    hazard_state_t    state_d, state_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic [BUB_W-1:0] bub_d, bub_q;

    logic mem_wait;
    logic timeout_hit;
    logic load_use;

    // Raw (pre-reset-gating) output values.
    logic s_if, s_id, s_ex, s_mem, f_id, f_ex, fault;

    always_comb begin
        mem_wait    = mem_req & ~mem_ready;
        // tmo_q counts wait cycles already spent, so this is the MEM_TIMEOUT-th one.
        timeout_hit = mem_wait && (tmo_q == TMO_LAST);
        load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        s_mem   = 1'b0;
        f_id    = 1'b0;
        f_ex    = 1'b0;
        fault   = 1'b0;
        state_d = state_q;
        tmo_d   = '0;
        bub_d   = bub_q;

        if (mem_wait && !timeout_hit) begin
            // Whole pipe frozen; a pending redirect stays visible in EX and is
            // handled once memory completes.
            s_if    = 1'b1;
            s_id    = 1'b1;
            s_ex    = 1'b1;
            s_mem   = 1'b1;
            state_d = MEM_WAIT;
            tmo_d   = tmo_q + TMO_W'(1);
        end else begin
            // Timeout cycle releases the stalls and otherwise behaves like a normal cycle.
            fault = timeout_hit;
            if (ex_redirect) begin
                f_id = 1'b1;
                f_ex = 1'b1;
                if (REDIRECT_BUBBLES > 0) begin
                    state_d = BUBBLE;
                    bub_d   = BUB_LOAD;
                end else begin
                    state_d = RUN;
                end
            end else if (state_q == BUBBLE) begin
                // ID holds a wrong-path fetch, so load-use is irrelevant here.
                f_id = 1'b1;
                if (bub_q <= BUB_W'(1)) begin
                    bub_d   = '0;
                    state_d = RUN;
                end else begin
                    bub_d = bub_q - BUB_W'(1);
                end
            end else begin
                state_d = RUN;
                if (load_use) begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    f_ex = 1'b1;
                end
            end
        end
    end

    // Nothing may stall or squash the pipe while it is held in reset.
    always_comb begin
        stall_if  = rstn & s_if;
        stall_id  = rstn & s_id;
        stall_ex  = rstn & s_ex;
        stall_mem = rstn & s_mem;
        flush_id  = rstn & f_id;
        flush_ex  = rstn & f_ex;
        mem_fault = rstn & fault;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            tmo_q   <= '0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            bub_q   <= bub_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (perf_clr),
        .inc (stall_if),
        .q   (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (perf_clr),
        .inc (flush_id),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench with a scoreboard queue: each driven cycle pushes its expected
// outputs, and a monitor on the falling edge pops and compares.
module tb_pipeline_hazard_controller;

    localparam int unsigned RB  = 2;
    localparam int unsigned MT  = 8;
    localparam int unsigned CW  = 4;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_fault}
    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] LU = 7'b1100010;
    localparam logic [6:0] MW = 7'b1111000;
    localparam logic [6:0] RD = 7'b0000110;
    localparam logic [6:0] BB = 7'b0000100;
    localparam logic [6:0] FT = 7'b0000001;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0, perf_clr = 1'b0;
    logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_fault;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        int         id;
        logic [6:0] outs;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REDIRECT_BUBBLES(RB),
        .MEM_TIMEOUT     (MT),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .perf_clr   (perf_clr),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .stall_ex   (stall_ex),
        .stall_mem  (stall_mem),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .mem_fault  (mem_fault),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    // One cycle of stimulus plus its expected response.
    task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic rdr,
                        input logic rq, input logic rdy, input logic clr,
                        input logic [6:0] eo, input logic [3:0] esc, input logic [3:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        rstn        = rn;
        id_rs1      = rs1;
        id_rs2      = rs2;
        ex_rd       = rd;
        ex_mem_read = mr;
        ex_redirect = rdr;
        mem_req     = rq;
        mem_ready   = rdy;
        perf_clr    = clr;
        step_no++;
        e.id   = step_no;
        e.outs = eo;
        e.sc   = esc;
        e.fc   = efc;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_fault};
                total++;
                if (got !== e.outs) begin
                    bad++;
                    $display("FAIL step%0d outs: got=%b want=%b", e.id, got, e.outs);
                end
                total++;
                if (stall_cnt !== e.sc) begin
                    bad++;
                    $display("FAIL step%0d stall_cnt: got=%0d want=%0d", e.id, stall_cnt, e.sc);
                end
                total++;
                if (flush_cnt !== e.fc) begin
                    bad++;
                    $display("FAIL step%0d flush_cnt: got=%0d want=%0d", e.id, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        // rn rs1 rs2 rd  mr rdr rq rdy clr  outs sc fc
        // Reset with hazard-provoking inputs: everything forced low.
        step(0, 0, 5, 5, 1, 1, 1, 0, 0, Z, 0, 0);
        step(0, 0, 5, 5, 1, 1, 1, 0, 0, Z, 0, 0);
        // Load-use
        step(1, 0, 5, 5, 1, 0, 0, 0, 0, LU, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, Z, 1, 0);   // ex_rd = x0
        step(1, 7, 3, 7, 1, 0, 0, 0, 0, LU, 1, 0);  // match on rs1
        step(1, 7, 3, 7, 0, 0, 0, 0, 0, Z, 2, 0);   // not a load
        // Redirect with two trailing bubbles; load-use ignored in BUBBLE
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, RD, 2, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, BB, 2, 1);
        step(1, 0, 5, 5, 1, 0, 0, 0, 0, BB, 2, 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 2, 3);
        // Memory wait of four cycles
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 2, 3);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 3, 3);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 4, 3);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 5, 3);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, Z, 6, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 6, 3);
        // Redirect held under memory wait, acted on at mem_ready
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, MW, 6, 3);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, MW, 7, 3);
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, RD, 8, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, BB, 8, 4);
        // New redirect inside BUBBLE reloads the count
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, RD, 8, 5);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, BB, 8, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, BB, 8, 7);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 8, 8);
        // Timeout: fault on the 8th wait cycle; stall_cnt saturates at 15
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 8, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 9, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 10, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 11, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 12, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 13, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 14, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, FT, 15, 8);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 15, 8);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, Z, 15, 8);
        // Reset mid-BUBBLE with stall_cnt saturated
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, RD, 15, 8);
        step(0, 0, 5, 5, 1, 0, 1, 0, 0, Z, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0);
        // perf_clr beats a same-cycle increment
        step(1, 0, 5, 5, 1, 0, 0, 0, 0, LU, 0, 0);
        step(1, 0, 5, 5, 1, 0, 0, 0, 1, LU, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0);
        // Reset mid-MEM_WAIT: no fault, back to RUN
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, MW, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, Z, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
